// File: rtl/seg_scan_if.sv
// Signal bundle between a nibble/dp data source and the seg_scan_mux display driver.
// The master supplies data, strobes and live controls; the slave drives the pins.
interface seg_scan_if #(
  parameter int NUM_DIGITS = 3
);
  logic [4*NUM_DIGITS-1:0] data;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    load;
  logic [NUM_DIGITS-1:0]   blank;
  logic                    lzs_en;
  logic [3:0]              bright;
  logic [7:0]              seg_full;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic                    frame_done;

  modport master (
    output data, dp_in, load, blank, lzs_en, bright,
    input  seg_full, digit_en, frame_done
  );

  modport slave (
    input  data, dp_in, load, blank, lzs_en, bright,
    output seg_full, digit_en, frame_done
  );
endinterface

// File: rtl/seg_scan_mux.sv
// Multiplexed 7-segment scanner: frame-synchronous load, dp/blank, leading-zero
// suppression, 16-level PWM brightness with a dark guard slice, frame-done strobe.
module seg_scan_mux #(
  parameter int NUM_DIGITS  = 3,
  parameter int SCAN_DIV    = 16384,
  parameter int SEG_ACT_LOW = 1,
  parameter int DIG_ACT_LOW = 0
) (
  input logic       sys_clk,
  input logic       sys_rst,
  seg_scan_if.slave bus
);
  localparam int PW      = $clog2(SCAN_DIV);
  localparam int DW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int SUB_LEN = SCAN_DIV / 16;
  localparam logic [PW-1:0] PHASE_MAX = PW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DIG_MAX   = DW'(NUM_DIGITS - 1);
  localparam logic [7:0] SEG_OFF = (SEG_ACT_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] DIG_OFF = (DIG_ACT_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  logic [PW-1:0]           phase_reg;
  logic [DW-1:0]           dig_idx_reg;
  logic [4*NUM_DIGITS-1:0] staging_reg;
  logic [NUM_DIGITS-1:0]   staging_dp_reg;
  logic [4*NUM_DIGITS-1:0] display_reg;
  logic [NUM_DIGITS-1:0]   display_dp_reg;
  logic                    pending_reg;
  logic [7:0]              seg_reg;
  logic [NUM_DIGITS-1:0]   digit_reg;
  logic                    frame_done_reg;

  logic [3:0]            sub;
  logic                  boundary;
  logic [3:0]            cur_nib;
  logic [NUM_DIGITS:0]   zero_from;
  logic [NUM_DIGITS-1:0] suppressed;
  logic [NUM_DIGITS-1:0] onehot;
  logic                  digit_on;
  logic [7:0]            seg_low;
  logic [7:0]            seg_next;
  logic [NUM_DIGITS-1:0] digit_next;

  function automatic logic [7:0] font_low(input logic [3:0] nib);
    case (nib)
      4'h0: font_low = 8'hC0;  4'h1: font_low = 8'hF9;
      4'h2: font_low = 8'hA4;  4'h3: font_low = 8'hB0;
      4'h4: font_low = 8'h99;  4'h5: font_low = 8'h92;
      4'h6: font_low = 8'h82;  4'h7: font_low = 8'hF8;
      4'h8: font_low = 8'h80;  4'h9: font_low = 8'h90;
      4'hA: font_low = 8'h88;  4'hB: font_low = 8'h83;
      4'hC: font_low = 8'hA7;  4'hD: font_low = 8'hA1;
      4'hE: font_low = 8'h86;  default: font_low = 8'h8E;
    endcase
  endfunction

  assign sub      = 4'(phase_reg / PW'(SUB_LEN));
  assign boundary = (phase_reg == PHASE_MAX) && (dig_idx_reg == DIG_MAX);
  assign cur_nib  = display_reg[dig_idx_reg*4 +: 4];

  // zero_from[k] is set when every displayed nibble from k upward is zero.
  assign zero_from[NUM_DIGITS] = 1'b1;
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign zero_from[gi] = (display_reg[4*gi +: 4] == 4'h0) && zero_from[gi+1];
      assign onehot[gi]    = (dig_idx_reg == DW'(gi));
      if (gi == 0) begin : g_lsd
        assign suppressed[gi] = 1'b0;
      end else begin : g_upper
        assign suppressed[gi] = bus.lzs_en && zero_from[gi];
      end
    end
  endgenerate

  // The top sub-slot (15) is always dark so adjacent digits never ghost.
  assign digit_on = !bus.blank[dig_idx_reg] && !suppressed[dig_idx_reg]
                    && (sub < bus.bright) && (sub != 4'hF);

  always_comb begin
    seg_low    = font_low(cur_nib);
    seg_low[7] = ~display_dp_reg[dig_idx_reg];
    seg_next   = SEG_OFF;
    digit_next = DIG_OFF;
    if (digit_on) begin
      seg_next   = (SEG_ACT_LOW != 0) ? seg_low : ~seg_low;
      digit_next = (DIG_ACT_LOW != 0) ? ~onehot : onehot;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      phase_reg      <= '0;
      dig_idx_reg    <= '0;
      staging_reg    <= '0;
      staging_dp_reg <= '0;
      display_reg    <= '0;
      display_dp_reg <= '0;
      pending_reg    <= 1'b0;
      seg_reg        <= SEG_OFF;
      digit_reg      <= DIG_OFF;
      frame_done_reg <= 1'b0;
    end else begin
      if (phase_reg == PHASE_MAX) begin
        phase_reg   <= '0;
        dig_idx_reg <= (dig_idx_reg == DIG_MAX) ? '0 : dig_idx_reg + 1'b1;
      end else begin
        phase_reg <= phase_reg + 1'b1;
      end

      if (bus.load) begin
        staging_reg    <= bus.data;
        staging_dp_reg <= bus.dp_in;
      end

      // A load landing on the boundary itself bypasses staging straight to display.
      if (boundary && (pending_reg || bus.load)) begin
        display_reg    <= bus.load ? bus.data  : staging_reg;
        display_dp_reg <= bus.load ? bus.dp_in : staging_dp_reg;
        pending_reg    <= 1'b0;
      end else if (bus.load) begin
        pending_reg <= 1'b1;
      end

      seg_reg        <= seg_next;
      digit_reg      <= digit_next;
      frame_done_reg <= boundary;
    end
  end

  assign bus.seg_full   = seg_reg;
  assign bus.digit_en   = digit_reg;
  assign bus.frame_done = frame_done_reg;
endmodule

// File: tb/tb_seg_scan_mux.sv
// Bench for seg_scan_mux (N=3, SCAN_DIV=32): directed scenarios plus randomized
// traffic, all compared cycle by cycle against a frame-level behavioural model.
module tb_seg_scan_mux;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg_scan_if #(.NUM_DIGITS(3)) bus ();

  seg_scan_mux #(
    .NUM_DIGITS (3),
    .SCAN_DIV   (32),
    .SEG_ACT_LOW(1),
    .DIG_ACT_LOW(0)
  ) dut (
    .sys_clk(clk),
    .sys_rst(rst),
    .bus    (bus)
  );

  int checks = 0;
  int failures = 0;

  logic [7:0] font [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                            8'h80, 8'h90, 8'h88, 8'h83, 8'hA7, 8'hA1, 8'h86, 8'h8E};

  // model state: time since reset release, displayed and staged values
  int         m_t;
  logic [3:0] m_disp [3];
  logic [3:0] m_stage [3];
  logic [2:0] m_dp, m_stage_dp;
  bit         m_pend;
  logic [7:0] exp_seg;
  logic [2:0] exp_dig;
  logic       exp_fd;

  // observation statistics
  int         mm;
  string      mm_msg;
  int         lit_cnt [3];
  logic [7:0] seg_last [3];
  bit         seg_var [3];
  int         fd_cnt;

  task automatic model_reset();
    m_t = 0; m_pend = 0; m_dp = '0; m_stage_dp = '0;
    for (int k = 0; k < 3; k++) begin m_disp[k] = '0; m_stage[k] = '0; end
    exp_seg = 8'hFF; exp_dig = 3'b000; exp_fd = 1'b0;
  endtask

  task automatic clear_stats();
    mm = 0; fd_cnt = 0;
    for (int k = 0; k < 3; k++) begin lit_cnt[k] = 0; seg_last[k] = 8'h00; seg_var[k] = 0; end
  endtask

  // Advance one clock: predict the next registered outputs, then observe the DUT.
  task automatic tick();
    int ph, dg, sb;
    bit supp, on, bnd;
    logic [7:0] s;
    ph = m_t % 32; dg = (m_t / 32) % 3; sb = ph / 2;
    supp = 0;
    if (bus.lzs_en && dg >= 1) begin
      supp = 1;
      for (int k = dg; k < 3; k++) if (m_disp[k] != 4'd0) supp = 0;
    end
    on = !bus.blank[dg] && !supp && (sb < int'(bus.bright)) && (sb != 15);
    s = 8'hFF; exp_dig = 3'b000;
    if (on) begin
      s = font[m_disp[dg]];
      if (m_dp[dg]) s[7] = 1'b0;
      exp_dig = 3'b001 << dg;
    end
    exp_seg = s;
    bnd = (ph == 31) && (dg == 2);
    exp_fd = bnd;
    if (bus.load) begin
      for (int k = 0; k < 3; k++) m_stage[k] = bus.data[4*k +: 4];
      m_stage_dp = bus.dp_in;
      m_pend = 1;
    end
    if (bnd && m_pend) begin
      m_disp = m_stage; m_dp = m_stage_dp; m_pend = 0;
    end
    m_t++;
    @(posedge clk); #1;
    if (bus.seg_full !== exp_seg || bus.digit_en !== exp_dig || bus.frame_done !== exp_fd) begin
      if (mm == 0)
        mm_msg = $sformatf("t=%0d seg=%h/%h dig=%b/%b fd=%b/%b", m_t, bus.seg_full, exp_seg,
                           bus.digit_en, exp_dig, bus.frame_done, exp_fd);
      mm++;
    end
    for (int k = 0; k < 3; k++) begin
      if (bus.digit_en === (3'b001 << k)) begin
        if (lit_cnt[k] > 0 && bus.seg_full !== seg_last[k]) seg_var[k] = 1;
        seg_last[k] = bus.seg_full;
        lit_cnt[k]++;
      end
    end
    if (bus.frame_done === 1'b1) fd_cnt++;
  endtask

  task automatic sync_frame();
    int n;
    n = 0;
    do begin tick(); n++; end while (!exp_fd && n < 400);
    checks++;
    if (!exp_fd) begin failures++; $display("FAIL sync_timeout waited=%0d cycles, required boundary", n); end
  endtask

  task automatic do_load(input logic [11:0] d, input logic [2:0] dp);
    bus.data = d; bus.dp_in = dp; bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (bus.seg_full !== 8'hFF) begin failures++; $display("FAIL reset_seg got=%h want=FF", bus.seg_full); end
    checks++;
    if (bus.digit_en !== 3'b000) begin failures++; $display("FAIL reset_dig got=%b want=000", bus.digit_en); end
    checks++;
    if (bus.frame_done !== 1'b0) begin failures++; $display("FAIL reset_fd got=%b want=0", bus.frame_done); end
    rst = 1'b0;
    model_reset();
    clear_stats();
    repeat (8) tick();
    checks++;
    if (mm !== 0) begin failures++; $display("FAIL reset_release model mismatches=%0d want=0 first: %s", mm, mm_msg); end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    logic [7:0] want [3];
    want = '{8'hF8, 8'h08, 8'hB0};
    do_load(12'h3A7, 3'b010);
    sync_frame();
    clear_stats();
    repeat (96) tick();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (lit_cnt[k] !== 30) begin failures++; $display("FAIL basic_lit%0d got=%0d want=30", k, lit_cnt[k]); end
      checks++;
      if (seg_last[k] !== want[k] || seg_var[k]) begin
        failures++; $display("FAIL basic_seg%0d got=%h var=%0d want=%h", k, seg_last[k], seg_var[k], want[k]);
      end
    end
    checks++;
    if (fd_cnt !== 1) begin failures++; $display("FAIL basic_frame_done got=%0d want=1", fd_cnt); end
    checks++;
    if (mm !== 0) begin failures++; $display("FAIL basic_model mismatches=%0d first: %s", mm, mm_msg); end
    $display("test_basic done");
  endtask

  task automatic test_tear_free();
    logic [7:0] old_seg [3];
    old_seg = '{8'hF8, 8'h08, 8'hB0};
    clear_stats();
    do_load(12'h111, 3'b000);
    repeat (20) tick();
    do_load(12'h222, 3'b000);
    sync_frame();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (seg_last[k] !== old_seg[k] || seg_var[k]) begin
        failures++; $display("FAIL tear_old%0d got=%h var=%0d want=%h", k, seg_last[k], seg_var[k], old_seg[k]);
      end
    end
    checks++;
    if (mm !== 0) begin failures++; $display("FAIL tear_model_pre mismatches=%0d first: %s", mm, mm_msg); end
    clear_stats();
    repeat (96) tick();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (lit_cnt[k] !== 30 || seg_last[k] !== 8'hA4 || seg_var[k]) begin
        failures++; $display("FAIL tear_new%0d lit=%0d seg=%h var=%0d want 30/A4", k, lit_cnt[k], seg_last[k], seg_var[k]);
      end
    end
    checks++;
    if (mm !== 0) begin failures++; $display("FAIL tear_model_post mismatches=%0d first: %s", mm, mm_msg); end
    $display("test_tear_free done");
  endtask

  task automatic test_boundary_load();
    logic [7:0] want [3];
    int n;
    want = '{8'h82, 8'h92, 8'h99};
    clear_stats();
    n = 0;
    while (!((m_t % 32) == 31 && ((m_t / 32) % 3) == 2) && n < 200) begin tick(); n++; end
    do_load(12'h456, 3'b000);
    checks++;
    if (!exp_fd) begin failures++; $display("FAIL bnd_align load not on boundary, got fd_exp=%b want=1", exp_fd); end
    clear_stats();
    repeat (96) tick();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (lit_cnt[k] !== 30 || seg_last[k] !== want[k] || seg_var[k]) begin
        failures++; $display("FAIL bnd_seg%0d lit=%0d seg=%h var=%0d want 30/%h", k, lit_cnt[k], seg_last[k], seg_var[k], want[k]);
      end
    end
    checks++;
    if (mm !== 0) begin failures++; $display("FAIL bnd_model mismatches=%0d first: %s", mm, mm_msg); end
    $display("test_boundary_load done");
  endtask

  task automatic test_lzs();
    logic [11:0] pat [3];
    int          want_lit [3][3];
    logic [7:0]  want_seg [3][2];
    pat      = '{12'h007, 12'h000, 12'h070};
    want_lit = '{'{30, 0, 0}, '{30, 0, 0}, '{30, 30, 0}};
    want_seg = '{'{8'hF8, 8'h00}, '{8'hC0, 8'h00}, '{8'hC0, 8'hF8}};
    bus.lzs_en = 1'b1;
    for (int p = 0; p < 3; p++) begin
      do_load(pat[p], 3'b111);
      sync_frame();
      clear_stats();
      repeat (96) tick();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (lit_cnt[k] !== want_lit[p][k]) begin
          failures++; $display("FAIL lzs_lit p=%03h d%0d got=%0d want=%0d", pat[p], k, lit_cnt[k], want_lit[p][k]);
        end
      end
      for (int k = 0; k < 2; k++) begin
        if (want_lit[p][k] != 0) begin
          checks++;
          // dp requested on all digits: lit digits carry it, so bit7 clears
          if (seg_last[k] !== (want_seg[p][k] & 8'h7F)) begin
            failures++; $display("FAIL lzs_seg p=%03h d%0d got=%h want=%h", pat[p], k, seg_last[k], want_seg[p][k] & 8'h7F);
          end
        end
      end
      checks++;
      if (mm !== 0) begin failures++; $display("FAIL lzs_model p=%03h mismatches=%0d first: %s", pat[p], mm, mm_msg); end
    end
    bus.lzs_en = 1'b0;
    $display("test_lzs done");
  endtask

  task automatic test_bright_blank();
    logic [3:0] br [3];
    logic [2:0] bl [3];
    int         want [3][3];
    br   = '{4'd4, 4'd0, 4'd15};
    bl   = '{3'b000, 3'b000, 3'b100};
    want = '{'{8, 8, 8}, '{0, 0, 0}, '{30, 30, 0}};
    for (int p = 0; p < 3; p++) begin
      bus.bright = br[p]; bus.blank = bl[p];
      sync_frame();
      clear_stats();
      repeat (96) tick();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (lit_cnt[k] !== want[p][k]) begin
          failures++; $display("FAIL bright_lit br=%0d bl=%b d%0d got=%0d want=%0d", br[p], bl[p], k, lit_cnt[k], want[p][k]);
        end
      end
      checks++;
      if (mm !== 0) begin failures++; $display("FAIL bright_model mismatches=%0d first: %s", mm, mm_msg); end
    end
    bus.bright = 4'd15; bus.blank = 3'b000;
    $display("test_bright_blank done");
  endtask

  task automatic test_random();
    logic [11:0] d;
    for (int it = 0; it < 16; it++) begin
      clear_stats();
      bus.bright = 4'($urandom_range(0, 15));
      bus.blank  = 3'($urandom_range(0, 7)) & 3'($urandom_range(0, 7));
      bus.lzs_en = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 120)) tick();
      // mask nibbles so leading zeros show up often
      d = 12'($urandom) & {{4{1'($urandom_range(0, 1))}}, {4{1'($urandom_range(0, 1))}}, 4'hF};
      do_load(d, 3'($urandom_range(0, 7)));
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(0, 40)) tick();
        do_load(12'($urandom), 3'($urandom_range(0, 7)));
      end
      repeat ($urandom_range(50, 200)) tick();
      checks++;
      if (mm !== 0) begin failures++; $display("FAIL random_it%0d mismatches=%0d first: %s", it, mm, mm_msg); end
    end
    bus.bright = 4'd15; bus.blank = 3'b000; bus.lzs_en = 1'b0;
    $display("test_random done");
  endtask

  task automatic test_reset_mid();
    do_load(12'h888, 3'b000);
    sync_frame();
    repeat (42) tick();
    do_load(12'h999, 3'b111);
    repeat (3) tick();
    rst = 1'b1;
    #1;
    checks++;
    if (bus.seg_full !== 8'hFF) begin failures++; $display("FAIL rstmid_seg got=%h want=FF", bus.seg_full); end
    checks++;
    if (bus.digit_en !== 3'b000) begin failures++; $display("FAIL rstmid_dig got=%b want=000", bus.digit_en); end
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    clear_stats();
    repeat (192) tick();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (lit_cnt[k] !== 60 || seg_last[k] !== 8'hC0 || seg_var[k]) begin
        failures++; $display("FAIL rstmid_d%0d lit=%0d seg=%h var=%0d want 60/C0", k, lit_cnt[k], seg_last[k], seg_var[k]);
      end
    end
    checks++;
    if (fd_cnt !== 2) begin failures++; $display("FAIL rstmid_fd got=%0d want=2", fd_cnt); end
    checks++;
    if (mm !== 0) begin failures++; $display("FAIL rstmid_model mismatches=%0d first: %s", mm, mm_msg); end
    $display("test_reset_mid done");
  endtask

  initial begin
    bus.data = '0; bus.dp_in = '0; bus.load = 1'b0; bus.blank = '0;
    bus.lzs_en = 1'b0; bus.bright = 4'd15;
    model_reset();
    clear_stats();
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_tear_free();
    test_boundary_load();
    test_lzs();
    test_bright_blank();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
